equal_segmentation_corrector32: RTL
===================================

Name: equal_segmentation_corrector32

Overview:
- Sequential companion to the equal-segmentation approximate adder.
- Accepts an operand pair and returns two results: the approximate segmented sum one cycle after acceptance, and the exact sum after inter-segment carries have been repaired, one segment per cycle.
- Also flags whether the approximate and exact sums differ.
- Sits behind the approximate datapath for error-resilient units that need an accurate result on demand.

Parameters:
- width, 32, operand width in bits.
- segment, 8, segment width in bits. Legal only if width % segment == 0 and width/segment >= 2.
- nseg (localparam), width/segment, number of segments.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  operand pair valid.
- ready_o  output  1  block can accept operands (high only in IDLE).
- add1_i  input  width  operand A.
- add2_i  input  width  operand B.
- approx_valid_o  output  1  one-cycle pulse; approx_o is valid.
- approx_o  output  width+1  segmented approximate sum.
- exact_valid_o  output  1  exact_o and error_o are valid; held until accepted.
- exact_ready_i  input  1  consumer accepts the exact result.
- exact_o  output  width+1  exact sum of add1_i and add2_i.
- error_o  output  1  1 when exact_o != approx_o.

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE, all registers cleared.
  - approx_valid_o=0, approx_o=0, exact_valid_o=0, exact_o=0, error_o=0.
  - ready_o=1 (state is IDLE), but inputs are ignored while rst_ni is low.
  - Reset mid-operation abandons the transaction; no result is ever produced for it.
- Approximate sum:
  - Each segment k adds independently with carry-in 0, giving raw sum s[k] and raw carry-out c[k].
  - approx_o = {c[nseg-1], s[nseg-1], ..., s[0]}.
- States: IDLE, CORR, DONE.
- IDLE: ready_o=1. Acceptance is valid_i & ready_o at an edge (edge T).
  - At edge T: register the operands, s[], c[] and approx_o; load the working result W = approx_o; load carry register cr = c[0]; set idx = 1.
  - If c[0..nseg-2] are all 0, go to DONE; otherwise go to CORR.
- approx_valid_o is high for exactly the one cycle following edge T, whatever state is entered.
- CORR, one edge per segment at the current idx:
  - If cr=1, W segment idx += 1 (mod 2^segment).
  - next cr = c[idx] | (cr & (s[idx] == all ones)).
  - If idx == nseg-1: W[width] = next cr; go to DONE.
  - Else if next cr == 0 and c[idx+1..nseg-2] are all 0: go to DONE (early termination).
  - Else idx += 1 and cr = next cr.
- DONE: exact_valid_o=1, exact_o=W, error_o=(W != approx_o). All hold stable until exact_ready_i=1 at an edge, then go to IDLE.
  - ready_o is not asserted in the same cycle as exact_valid_o; back-to-back acceptance needs one IDLE cycle.
- Latency: the exact result is visible 1 cycle after T with no inter-segment carries, and at most nseg cycles after T (4 at defaults).
- Carry out of the top segment lands in bit width; exact_o always equals add1_i + add2_i computed at width+1 bits.
- valid_i and operand changes outside IDLE are ignored.
- Simultaneous valid_i and exact_ready_i in DONE: only the exact handshake completes; the operands are not accepted.

Test Plan:
- Reset asserted mid-CORR with 0xFFFFFFFF+0x00000001 -> all outputs 0 immediately; after release ready_o=1 and no exact_valid_o appears.
- 0x00000012+0x00000034 -> approx_valid_o and exact_valid_o both high at T+1; approx_o=exact_o=0x0_00000046; error_o=0.
- 0x000000FF+0x00000001 -> approx_o=0x0_00000000 at T+1; early termination; exact_valid_o at T+2 with exact_o=0x0_00000100; error_o=1.
- 0xFFFFFFFF+0x00000001 -> approx_o=0x0_FFFFFF00; full ripple; exact_valid_o at T+4 with exact_o=0x1_00000000; error_o=1.
- 0x80FF80FF+0x80018001 (c[0],c[1],c[2],c[3] all 1) -> approx_o=0x1_00000000; exact_o=0x1_01010100 at T+4; error_o=1.
- Hold exact_ready_i=0 for 5 cycles in DONE with valid_i toggling -> exact_valid_o and outputs stay stable, no new acceptance; release -> IDLE and ready_o=1 next cycle.

Source files
------------

// File: rtl/equal_segmentation_corrector32.sv
// Segmented approximate adder with a sequential carry-repair stage: the approximate
// sum is published one cycle after acceptance, the exact sum after ripple correction.
module equal_segmentation_corrector32 #(
  parameter int width   = 32,
  parameter int segment = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [width-1:0] add1_i,
  input  logic [width-1:0] add2_i,
  output logic             approx_valid_o,
  output logic [width:0]   approx_o,
  output logic             exact_valid_o,
  input  logic             exact_ready_i,
  output logic [width:0]   exact_o,
  output logic             error_o
);

  localparam int nseg = width / segment;
  localparam int IW   = $clog2(nseg + 1);

  if ((width % segment) != 0 || nseg < 2) begin : g_bad_params
    $error("equal_segmentation_corrector32: width must be a multiple of segment with at least two segments");
  end

  typedef enum logic [1:0] {IDLE, CORR, DONE} state_t;

  state_t            state;
  logic [width-1:0]  s_p0;
  logic [nseg-1:0]   c_p0;
  logic [width:0]    approx_p0;
  logic              vld_p0;
  logic [width:0]    w_p1;
  logic              cr_p1;
  logic [IW-1:0]     idx_p1;

  // Independent per-segment adds, each with carry-in 0
  logic [width-1:0]  s_in;
  logic [nseg-1:0]   c_in;
  logic [width:0]    approx_in;

  always_comb begin
    s_in = '0;
    c_in = '0;
    for (int k = 0; k < nseg; k++) begin
      {c_in[k], s_in[k*segment +: segment]} =
        {1'b0, add1_i[k*segment +: segment]} + {1'b0, add2_i[k*segment +: segment]};
    end
  end

  assign approx_in = {c_in[nseg-1], s_in};

  // Repair of segment idx_p1 using the carry arriving from below
  int                base;
  int                base_up;
  logic [segment-1:0] w_seg;
  logic [segment-1:0] s_seg;
  logic [segment-1:0] w_seg_inc;
  logic [width:0]    seg_mask;
  logic [width:0]    seg_new;
  logic [width:0]    w_upd;
  logic [nseg-2:0]   c_mid;
  logic              c_at;
  logic              next_cr;
  logic              higher_zero;
  logic              last;

  always_comb begin
    base        = int'(idx_p1) * segment;
    base_up     = int'(idx_p1) + 1;
    w_seg       = segment'(w_p1 >> base);
    s_seg       = segment'(s_p0 >> base);
    w_seg_inc   = cr_p1 ? w_seg + 1'b1 : w_seg;
    seg_mask    = {{(width+1-segment){1'b0}}, {segment{1'b1}}} << base;
    seg_new     = {{(width+1-segment){1'b0}}, w_seg_inc} << base;
    w_upd       = (w_p1 & ~seg_mask) | seg_new;
    c_at        = |(c_p0 & ({{(nseg-1){1'b0}}, 1'b1} << idx_p1));
    next_cr     = c_at | (cr_p1 & (s_seg == {segment{1'b1}}));
    c_mid       = c_p0[nseg-2:0];
    higher_zero = ((c_mid >> base_up) == '0);
    last        = (idx_p1 == IW'(nseg - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      s_p0      <= '0;
      c_p0      <= '0;
      approx_p0 <= '0;
      vld_p0    <= 1'b0;
      w_p1      <= '0;
      cr_p1     <= 1'b0;
      idx_p1    <= '0;
    end else begin
      vld_p0 <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            s_p0      <= s_in;
            c_p0      <= c_in;
            approx_p0 <= approx_in;
            vld_p0    <= 1'b1;
            w_p1      <= approx_in;
            cr_p1     <= c_in[0];
            idx_p1    <= IW'(1);
            state     <= (c_in[nseg-2:0] == '0) ? DONE : CORR;
          end
        end
        CORR: begin
          w_p1 <= last ? {next_cr, w_upd[width-1:0]} : w_upd;
          if (last || (!next_cr && higher_zero)) begin
            state <= DONE;
          end else begin
            idx_p1 <= idx_p1 + IW'(1);
            cr_p1  <= next_cr;
          end
        end
        DONE: begin
          if (exact_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o        = (state == IDLE);
  assign approx_valid_o = vld_p0;
  assign approx_o       = approx_p0;
  assign exact_valid_o  = (state == DONE);
  assign exact_o        = exact_valid_o ? w_p1 : '0;
  assign error_o        = exact_valid_o & (w_p1 != approx_p0);

endmodule
